demux_1to4_stream: RTL and testbench

- Catalog element that is the distribution-side counterpart of the 4:1 mux.
- Takes one valid/ready input stream and routes each accepted word to one of four output channels.
- The channel is chosen by an explicit select (steered mode) or by a rotating pointer (round-robin mode).
- Each output channel has its own small FIFO, so one stalled consumer does not lose data.

---
 rtl/demux_1to4_stream.sv | 94 +++++++++
 tb/tb_demux_1to4_stream.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to4_stream.sv
// demux_1to4_stream: routes a valid/ready input stream to four output channels,
// each buffered by its own small FIFO. The target channel comes from in_sel
// (steered) or from a strictly rotating pointer (round-robin).
module demux_1to4_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [1:0]           rr_ptr,
    output logic [15:0]          acc_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem  [4][DEPTH];
    logic [AW:0]      wptr [4];
    logic [AW:0]      rptr [4];
    logic [3:0]       full;
    logic [3:0]       empty;
    logic [3:0]       pop;
    logic [1:0]       target;
    logic             push;

    // FIFO status flags: extra pointer MSB distinguishes full from empty
    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < 4; i++) begin
            empty[i] = (wptr[i] == rptr[i]);
            full[i]  = (wptr[i][AW] != rptr[i][AW]) &&
                       (wptr[i][AW-1:0] == rptr[i][AW-1:0]);
        end
    end

    // Target selection and input handshake; in_ready never looks at in_valid
    always_comb begin
        target   = in_mode ? rr_ptr : in_sel;
        in_ready = ~full[target];
        push     = in_valid & in_ready;
    end

    // Output side: head word of each non-empty FIFO, zero when empty
    always_comb begin
        out_data  = '0;
        out_valid = ~empty;
        pop       = ~empty & out_ready;
        for (int i = 0; i < 4; i++) begin
            if (!empty[i]) begin
                out_data[i*WIDTH +: WIDTH] = mem[i][rptr[i][AW-1:0]];
            end
        end
    end

    // FIFO storage, pointers, rotation pointer and accept counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                for (int j = 0; j < int'(DEPTH); j++) begin
                    mem[i][j] <= '0;
                end
            end
            rr_ptr    <= 2'd0;
            acc_count <= 16'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pop[i]) begin
                    rptr[i] <= rptr[i] + (AW+1)'(1);
                end
                if (push && (target == 2'(i))) begin
                    mem[i][wptr[i][AW-1:0]] <= in_data;
                    wptr[i] <= wptr[i] + (AW+1)'(1);
                end
            end
            if (push) begin
                acc_count <= acc_count + 16'd1;
                if (in_mode) begin
                    rr_ptr <= rr_ptr + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Testbench for demux_1to4_stream: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_demux_1to4_stream;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [WIDTH-1:0]   in_data = '0;
    logic [1:0]         in_sel = '0;
    logic               in_mode = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready = '0;
    logic [1:0]         rr_ptr;
    logic [15:0]        acc_count;

    int n_checks = 0;
    int n_fail   = 0;

    demux_1to4_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr),
        .acc_count (acc_count)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per channel, a rotation index and a counter
    logic [WIDTH-1:0] mq [4][$];
    int               m_rr  = 0;
    int               m_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_rr  = 0;
            m_cnt = 0;
        end else begin
            int  tgt;
            bit  acc;
            tgt = in_mode ? m_rr : int'(in_sel);
            acc = in_valid && (mq[tgt].size() < DEPTH);
            for (int i = 0; i < 4; i++) begin
                if (mq[i].size() > 0 && out_ready[i]) void'(mq[i].pop_front());
            end
            if (acc) begin
                mq[tgt].push_back(in_data);
                m_cnt = (m_cnt + 1) % 65536;
                if (in_mode) m_rr = (m_rr + 1) % 4;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        int tgt;
        logic [4*WIDTH-1:0] e_data;
        logic [3:0]         e_valid;
        tgt     = in_mode ? m_rr : int'(in_sel);
        e_data  = '0;
        e_valid = '0;
        for (int i = 0; i < 4; i++) begin
            if (mq[i].size() > 0) begin
                e_valid[i] = 1'b1;
                e_data[i*WIDTH +: WIDTH] = mq[i][0];
            end
        end
        check("model_in_ready", 64'(in_ready), 64'(mq[tgt].size() < DEPTH));
        check("model_out_valid", 64'(out_valid), 64'(e_valid));
        check("model_out_data", 64'(out_data), 64'(e_data));
        check("model_rr_ptr", 64'(rr_ptr), 64'(m_rr));
        check("model_acc_count", 64'(acc_count), 64'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] chan(input int i);
        return out_data[i*WIDTH +: WIDTH];
    endfunction

    initial begin
        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_rr_ptr", 64'(rr_ptr), 64'h0);
        check("rst_acc_count", 64'(acc_count), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        #1;
        rst = 1'b0;
        tick();

        // Steered pushes into channel 2
        in_mode = 1'b0; in_sel = 2'd2; in_valid = 1'b1; in_data = 8'h11;
        tick();
        check("steer_valid_first", 64'(out_valid), 64'h4);
        in_data = 8'h22;
        tick();
        check("steer_in_ready_full", 64'(in_ready), 64'h0);
        check("steer_acc", 64'(acc_count), 64'h2);
        in_valid = 1'b0;
        out_ready = 4'b0100;
        check("steer_head0", 64'(chan(2)), 64'h11);
        tick();
        check("steer_head1", 64'(chan(2)), 64'h22);
        tick();
        check("steer_drained", 64'(out_valid), 64'h0);
        out_ready = 4'b0000;

        // Round-robin rotation
        pulse_reset();
        tick();
        in_mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = WIDTH'(8'hA0 + k);
            tick();
            check("rr_route", 64'(chan(k % 4)), 64'(8'hA0 + k));
        end
        in_valid = 1'b0;
        check("rr_ptr_end", 64'(rr_ptr), 64'h2);
        check("rr_acc_end", 64'(acc_count), 64'h6);
        tick();
        tick();

        // Round-robin stall on a full channel 1
        pulse_reset();
        tick();
        out_ready = 4'b0000;
        in_mode = 1'b1; in_valid = 1'b1; in_data = 8'h0F;
        tick();
        in_mode = 1'b0; in_sel = 2'd1; in_data = 8'hB0;
        tick();
        in_data = 8'hB1;
        tick();
        in_mode = 1'b1; in_data = 8'hC0;
        for (int k = 0; k < 5; k++) begin
            check("stall_in_ready", 64'(in_ready), 64'h0);
            check("stall_rr", 64'(rr_ptr), 64'h1);
            tick();
        end
        out_ready = 4'b0010;
        tick();
        out_ready = 4'b0000;
        check("stall_release", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        check("stall_rr_adv", 64'(rr_ptr), 64'h2);
        check("stall_ch1_head", 64'(chan(1)), 64'hB1);
        out_ready = 4'b0010;
        tick();
        check("stall_ch1_landed", 64'(chan(1)), 64'hC0);
        out_ready = 4'b1111;
        tick();
        out_ready = 4'b0000;

        // Full channel with simultaneous pop
        pulse_reset();
        tick();
        in_mode = 1'b0; in_sel = 2'd0; in_valid = 1'b1; in_data = 8'hD0;
        tick();
        in_data = 8'hD1;
        tick();
        in_data = 8'hD2; out_ready = 4'b0001;
        check("full_no_ready", 64'(in_ready), 64'h0);
        tick();
        out_ready = 4'b0000;
        check("full_after_pop_ready", 64'(in_ready), 64'h1);
        check("full_after_pop_head", 64'(chan(0)), 64'hD1);
        tick();
        in_valid = 1'b0;
        check("full_refilled", 64'(in_ready), 64'h0);
        check("full_acc", 64'(acc_count), 64'h3);

        // Async reset mid-stream with all four channels holding data
        pulse_reset();
        tick();
        in_mode = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = WIDTH'(8'h50 + k);
            tick();
        end
        in_valid = 1'b0;
        check("pre_reset_all_valid", 64'(out_valid), 64'hF);
        #1;
        rst = 1'b1;
        #1;
        check("async_out_valid", 64'(out_valid), 64'h0);
        check("async_out_data", 64'(out_data), 64'h0);
        check("async_rr", 64'(rr_ptr), 64'h0);
        check("async_acc", 64'(acc_count), 64'h0);
        #1;
        rst = 1'b0;
        tick();
        in_mode = 1'b0; in_sel = 2'd2; in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_valid = 1'b0;
        check("post_reset_valid", 64'(out_valid), 64'h4);
        check("post_reset_data", 64'(chan(2)), 64'h11);

        // acc_count wrap after 65536 accepts
        pulse_reset();
        tick();
        in_mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1; in_data = 8'h77;
        for (int k = 0; k < 65535; k++) tick();
        in_valid = 1'b0;
        check("wrap_pre", 64'(acc_count), 64'hFFFF);
        check("wrap_pre_rr", 64'(rr_ptr), 64'h3);
        tick();
        tick();
        in_valid = 1'b1; in_data = 8'hE5;
        tick();
        in_valid = 1'b0;
        check("wrap_zero", 64'(acc_count), 64'h0);
        check("wrap_route_ch3", 64'(chan(3)), 64'hE5);
        check("wrap_rr", 64'(rr_ptr), 64'h0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
